// File: rtl/qtab_pkg.sv
// Shared types, constants and table helpers for the quantization-table controller.
// The JPEG tables here are used only when QTAB_JPEG_DEFAULT_EN is defined.
package qtab_pkg;

  localparam int QW            = 10;
  localparam int BEATS_PER_BLK = 32;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CR = 2'd1,
    CH_CB = 2'd2
  } ch_e;

  // Entry 0 is the leftmost element, so a table literal reads in stream order.
  typedef logic [0:63][QW-1:0] q_tab_t;

  localparam q_tab_t PASS_Q = {64{10'd1}};

  // ITU-T T.81 Annex K tables, reordered into zig-zag (stream) order.
  localparam q_tab_t JPEG_LUMA_Q = '{
    10'd16,  10'd11,  10'd12,  10'd14,  10'd12,  10'd10,  10'd16,  10'd14,
    10'd13,  10'd14,  10'd18,  10'd17,  10'd16,  10'd19,  10'd24,  10'd40,
    10'd26,  10'd24,  10'd22,  10'd22,  10'd24,  10'd49,  10'd35,  10'd37,
    10'd29,  10'd40,  10'd58,  10'd51,  10'd61,  10'd60,  10'd57,  10'd51,
    10'd56,  10'd55,  10'd64,  10'd72,  10'd92,  10'd78,  10'd64,  10'd68,
    10'd87,  10'd69,  10'd55,  10'd56,  10'd80,  10'd109, 10'd81,  10'd87,
    10'd95,  10'd98,  10'd103, 10'd104, 10'd103, 10'd62,  10'd77,  10'd113,
    10'd121, 10'd112, 10'd100, 10'd120, 10'd92,  10'd101, 10'd103, 10'd99
  };

  localparam q_tab_t JPEG_CHROMA_Q = '{
    10'd17, 10'd18, 10'd18, 10'd24, 10'd21, 10'd24, 10'd47, 10'd26,
    10'd26, 10'd47, 10'd99, 10'd66, 10'd56, 10'd66, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99,
    10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99, 10'd99
  };

  // A zero divisor would stall the divider, so it is stored as 1.
  function automatic logic [QW-1:0] guard_zero(input logic [QW-1:0] v);
    if (v == {QW{1'b0}}) begin
      return {{(QW-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/qtab_bank.sv
// One channel's double-buffered 64-entry table: one shadow write port and
// N registered active read ports.
module qtab_bank
  import qtab_pkg::*;
#(
  parameter int                  N         = 2,
  parameter int                  QW        = 10,
  parameter logic [0:63][QW-1:0] RESET_TAB = {64{10'd1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rd_bank,
  input  logic [N-1:0][5:0]    rd_idx,
  output logic [N-1:0][QW-1:0] rd_q,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [5:0]           wr_idx,
  input  logic [QW-1:0]        wr_data
);

  logic [0:63][QW-1:0] bank_r [2];

  // Table storage; writes land regardless of the pipeline enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r[0] <= RESET_TAB;
      bank_r[1] <= RESET_TAB;
    end else if (wr_en) begin
      bank_r[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Registered lookup so the entries line up with the delayed coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        rd_q[i] <= bank_r[rd_bank][rd_idx[i]];
      end
    end
  end

endmodule

// File: rtl/quant_table_ctrl.sv
// Quantization-table controller: 1-cycle coefficient passthrough with aligned
// Y/Cr/Cb table entries. Define QTAB_JPEG_DEFAULT_EN to reset to JPEG tables.
module quant_table_ctrl
  import qtab_pkg::*;
#(
  parameter int N  = 2,
  parameter int QW = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic signed [N-1:0][15:0]  in_data,
  input  logic                       in_eob,
  input  logic                       in_sob,
  input  logic                       in_sof,
  output logic                       out_valid,
  output logic signed [N-1:0][15:0]  out_data,
  output logic                       out_eob,
  output logic                       out_sob,
  output logic                       out_sof,
  output logic [N-1:0][QW-1:0]       out_q_y,
  output logic [N-1:0][QW-1:0]       out_q_cr,
  output logic [N-1:0][QW-1:0]       out_q_cb,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_ch,
  input  logic [5:0]                 cfg_idx,
  input  logic [QW-1:0]              cfg_data,
  input  logic                       cfg_commit,
  output logic                       swap_pending,
  output logic                       err
);

`ifdef QTAB_JPEG_DEFAULT_EN
  localparam q_tab_t Y_INIT = JPEG_LUMA_Q;
  localparam q_tab_t C_INIT = JPEG_CHROMA_Q;
`else
  localparam q_tab_t Y_INIT = PASS_Q;
  localparam q_tab_t C_INIT = PASS_Q;
`endif

  logic [4:0]          beat_r;
  logic [4:0]          beat_nxt_s;
  logic [4:0]          eff_beat_s;
  logic                bank_sel_r;
  logic                bank_sel_nxt_s;
  logic                pending_nxt_s;
  logic                err_nxt_s;
  logic                beat_acc_s;
  logic                swap_now_s;
  logic                frame_err_s;
  logic [N-1:0][5:0]   rd_idx_s;
  logic [QW-1:0]       wr_data_s;
  logic [2:0]          wr_en_s;

  // Beat tracking, framing checks, swap decision and config decode.
  always_comb begin
    eff_beat_s     = beat_r;
    beat_nxt_s     = beat_r;
    swap_now_s     = 1'b0;
    frame_err_s    = 1'b0;
    pending_nxt_s  = swap_pending;
    beat_acc_s     = en & in_valid;
    wr_en_s        = 3'b000;
    wr_data_s      = guard_zero(cfg_data);

    if (in_sob) begin
      eff_beat_s = 5'd0;
    end else begin
      eff_beat_s = beat_r;
    end

    for (int i = 0; i < N; i++) begin
      rd_idx_s[i] = 6'({1'b0, eff_beat_s} * 6'(N) + 6'(i));
    end

    if (beat_acc_s) begin
      swap_now_s  = in_sof & (swap_pending | cfg_commit);
      frame_err_s = (in_eob & (eff_beat_s != 5'd31))
                  | (in_sob & (beat_r != 5'd0))
                  | (!in_sob & (beat_r == 5'd0));
      if (in_sob) begin
        beat_nxt_s = 5'd1;
      end else begin
        beat_nxt_s = beat_r + 5'd1;
      end
    end else begin
      beat_nxt_s = beat_r;
    end

    // The swapping beat already reads the new bank; writes target the new shadow.
    bank_sel_nxt_s = bank_sel_r ^ swap_now_s;
    err_nxt_s      = err | frame_err_s;

    if (swap_now_s) begin
      pending_nxt_s = 1'b0;
    end else if (en && cfg_commit) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = swap_pending;
    end

    if (cfg_we) begin
      case (cfg_ch)
        CH_Y:    wr_en_s = 3'b001;
        CH_CR:   wr_en_s = 3'b010;
        CH_CB:   wr_en_s = 3'b100;
        default: wr_en_s = 3'b000;
      endcase
    end else begin
      wr_en_s = 3'b000;
    end
  end

  // Control state; everything holds while the pipeline is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r       <= 5'd0;
      bank_sel_r   <= 1'b0;
      swap_pending <= 1'b0;
      err          <= 1'b0;
    end else if (en) begin
      beat_r       <= beat_nxt_s;
      bank_sel_r   <= bank_sel_nxt_s;
      swap_pending <= pending_nxt_s;
      err          <= err_nxt_s;
    end
  end

  // Stream passthrough registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eob   <= 1'b0;
      out_sob   <= 1'b0;
      out_sof   <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_eob   <= in_valid & in_eob;
      out_sob   <= in_valid & in_sob;
      out_sof   <= in_valid & in_sof;
    end
  end

  qtab_bank #(.N(N), .QW(QW), .RESET_TAB(Y_INIT)) u_bank_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_bank (bank_sel_nxt_s),
    .rd_idx  (rd_idx_s),
    .rd_q    (out_q_y),
    .wr_en   (wr_en_s[0]),
    .wr_bank (~bank_sel_nxt_s),
    .wr_idx  (cfg_idx),
    .wr_data (wr_data_s)
  );

  qtab_bank #(.N(N), .QW(QW), .RESET_TAB(C_INIT)) u_bank_cr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_bank (bank_sel_nxt_s),
    .rd_idx  (rd_idx_s),
    .rd_q    (out_q_cr),
    .wr_en   (wr_en_s[1]),
    .wr_bank (~bank_sel_nxt_s),
    .wr_idx  (cfg_idx),
    .wr_data (wr_data_s)
  );

  qtab_bank #(.N(N), .QW(QW), .RESET_TAB(C_INIT)) u_bank_cb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_bank (bank_sel_nxt_s),
    .rd_idx  (rd_idx_s),
    .rd_q    (out_q_cb),
    .wr_en   (wr_en_s[2]),
    .wr_bank (~bank_sel_nxt_s),
    .wr_idx  (cfg_idx),
    .wr_data (wr_data_s)
  );

endmodule

// File: tb/tb_quant_table_ctrl.sv
// Directed self-checking bench for quant_table_ctrl (default build, passthrough reset tables).
module tb_quant_table_ctrl;

  localparam int N  = 2;
  localparam int QW = 10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      en;
  logic                      in_valid;
  logic signed [N-1:0][15:0] in_data;
  logic                      in_eob;
  logic                      in_sob;
  logic                      in_sof;
  logic                      out_valid;
  logic signed [N-1:0][15:0] out_data;
  logic                      out_eob;
  logic                      out_sob;
  logic                      out_sof;
  logic [N-1:0][QW-1:0]      out_q_y;
  logic [N-1:0][QW-1:0]      out_q_cr;
  logic [N-1:0][QW-1:0]      out_q_cb;
  logic                      cfg_we;
  logic [1:0]                cfg_ch;
  logic [5:0]                cfg_idx;
  logic [QW-1:0]             cfg_data;
  logic                      cfg_commit;
  logic                      swap_pending;
  logic                      err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [N-1:0][QW-1:0] ONES = {10'd1, 10'd1};

  quant_table_ctrl #(.N(N), .QW(QW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_eob       (in_eob),
    .in_sob       (in_sob),
    .in_sof       (in_sof),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_eob      (out_eob),
    .out_sob      (out_sob),
    .out_sof      (out_sof),
    .out_q_y      (out_q_y),
    .out_q_cr     (out_q_cr),
    .out_q_cb     (out_q_cb),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_idx      (cfg_idx),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .swap_pending (swap_pending),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Apply one beat for one clock; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic sob, input logic eob, input logic sof,
                       input logic [15:0] d0, input logic [15:0] d1);
    in_valid = v;
    in_sob   = sob;
    in_eob   = eob;
    in_sof   = sof;
    in_data  = {d1, d0};
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_sob     = 1'b0;
    in_eob     = 1'b0;
    in_sof     = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [5:0] idx, input logic [QW-1:0] val);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_idx  = idx;
    cfg_data = val;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    in_data = '0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_idx = 6'd0; cfg_data = 10'd0; cfg_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_sob, out_eob, out_sof} !== 4'b0000 || out_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stream: got v=%b data=%h, want 0", out_valid, out_data);
    end
    n_cmp++;
    if (out_q_y !== 20'd0 || out_q_cr !== 20'd0 || out_q_cb !== 20'd0) begin
      n_err++;
      $display("FAIL reset_q: got %h %h %h, want 0", out_q_y, out_q_cr, out_q_cb);
    end
    n_cmp++;
    if (swap_pending !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got pending=%b err=%b, want 0 0", swap_pending, err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    logic [15:0] d0;
    logic [15:0] d1;
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 32; b++) begin
        d0 = 16'(blk * 100 + b);
        d1 = ~d0;
        drive(1'b1, b == 0, b == 31, (blk == 0) && (b == 0), d0, d1);
        n_cmp++;
        if (out_data !== {d1, d0} || out_valid !== 1'b1 || out_sob !== (b == 0) ||
            out_eob !== (b == 31) || out_sof !== ((blk == 0) && (b == 0))) begin
          n_err++;
          $display("FAIL pass_stream blk%0d beat%0d: got data=%h sob=%b eob=%b sof=%b, want data=%h",
                   blk, b, out_data, out_sob, out_eob, out_sof, {d1, d0});
        end
        n_cmp++;
        if (out_q_y !== ONES || out_q_cr !== ONES || out_q_cb !== ONES) begin
          n_err++;
          $display("FAIL pass_q blk%0d beat%0d: got %h %h %h, want all 1", blk, b, out_q_y, out_q_cr, out_q_cb);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    n_cmp++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL pass_end: got valid=%b err=%b, want 0 0", out_valid, err);
    end
  endtask

  task automatic test_commit_mid();
    logic [N-1:0][QW-1:0] exp_q;
    cfg_write(2'd0, 6'd0, 10'd16);
    cfg_write(2'd0, 6'd1, 10'd11);
    for (int b = 0; b < 32; b++) begin
      cfg_commit = (b == 5);
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b), 16'(b + 1000));
      n_cmp++;
      if (out_q_y !== ONES || swap_pending !== (b >= 5)) begin
        n_err++;
        $display("FAIL commit_mid beat%0d: got q_y=%h pending=%b, want q_y=1 pending=%b",
                 b, out_q_y, swap_pending, b >= 5);
      end
    end
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b), 16'(b));
      exp_q = (b == 0) ? {10'd11, 10'd16} : ONES;
      n_cmp++;
      if (out_q_y !== exp_q || swap_pending !== 1'b0) begin
        n_err++;
        $display("FAIL commit_swap beat%0d: got q_y=%h pending=%b, want q_y=%h pending=0",
                 b, out_q_y, swap_pending, exp_q);
      end
    end
  endtask

  task automatic test_commit_same_cycle();
    logic [N-1:0][QW-1:0] exp_q;
    cfg_write(2'd0, 6'd0, 10'd5);
    cfg_write(2'd0, 6'd1, 10'd7);
    for (int b = 0; b < 32; b++) begin
      cfg_commit = (b == 0);
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b), 16'(b));
      exp_q = (b == 0) ? {10'd7, 10'd5} : ONES;
      n_cmp++;
      if (out_q_y !== exp_q || swap_pending !== 1'b0) begin
        n_err++;
        $display("FAIL commit_same beat%0d: got q_y=%h pending=%b, want q_y=%h pending=0",
                 b, out_q_y, swap_pending, exp_q);
      end
    end
  endtask

  task automatic test_zero_guard();
    cfg_write(2'd2, 6'd5, 10'd0);
    cfg_write(2'd2, 6'd4, 10'd9);
    cfg_write(2'd3, 6'd2, 10'd50);
    cfg_commit = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    n_cmp++;
    if (swap_pending !== 1'b1) begin
      n_err++;
      $display("FAIL zero_pending: got %b, want 1", swap_pending);
    end
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b), 16'(b));
      if (b == 0) begin
        n_cmp++;
        if (out_q_y !== {10'd11, 10'd16}) begin
          n_err++;
          $display("FAIL zero_old_bank: got q_y=%h, want %h", out_q_y, {10'd11, 10'd16});
        end
      end else if (b == 1) begin
        n_cmp++;
        if (out_q_cb !== ONES || out_q_y !== ONES) begin
          n_err++;
          $display("FAIL zero_ch3_ignored: got q_cb=%h q_y=%h, want 1 1", out_q_cb, out_q_y);
        end
      end else if (b == 2) begin
        n_cmp++;
        if (out_q_cb !== {10'd1, 10'd9} || out_q_cr !== ONES) begin
          n_err++;
          $display("FAIL zero_guard: got q_cb=%h q_cr=%h, want %h 1", out_q_cb, out_q_cr, {10'd1, 10'd9});
        end
      end
    end
  endtask

  task automatic test_framing_err();
    logic [N-1:0][QW-1:0] exp_y;
    logic [N-1:0][QW-1:0] exp_cb;
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_pre: got %b, want 0", err);
    end
    for (int b = 0; b <= 20; b++) begin
      drive(1'b1, b == 0, b == 20, 1'b0, 16'(b), 16'(b));
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_eob20: got %b, want 1", err);
    end
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, b == 0, b == 31, 1'b0, 16'(b + 7), 16'(b + 9));
      exp_y  = (b == 0) ? {10'd11, 10'd16} : ONES;
      exp_cb = (b == 2) ? {10'd1, 10'd9} : ONES;
      n_cmp++;
      if (out_q_y !== exp_y || out_q_cb !== exp_cb || err !== 1'b1) begin
        n_err++;
        $display("FAIL err_resync beat%0d: got q_y=%h q_cb=%h err=%b, want %h %h 1",
                 b, out_q_y, out_q_cb, err, exp_y, exp_cb);
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [N-1:0][QW-1:0] exp_q;
    for (int k = 0; k < 16; k++) begin
      cfg_write(2'd0, 6'(k), 10'(100 + k));
    end
    cfg_commit = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b + 200), 16'(b + 300));
      exp_q = (b < 8) ? {10'(101 + 2 * b), 10'(100 + 2 * b)} : ONES;
      n_cmp++;
      if (out_q_y !== exp_q || out_data !== {16'(b + 300), 16'(b + 200)}) begin
        n_err++;
        $display("FAIL freeze_seq beat%0d: got q_y=%h data=%h, want %h", b, out_q_y, out_data, exp_q);
      end
      if (b == 3) begin
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
          drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hdead, 16'hbeef);
          n_cmp++;
          if (out_q_y !== {10'd107, 10'd106} || out_data !== {16'd303, 16'd203} || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL freeze_hold cyc%0d: got q_y=%h data=%h, want %h %h",
                     c, out_q_y, out_data, {10'd107, 10'd106}, {16'd303, 16'd203});
          end
        end
        en = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 10; b++) begin
      drive(1'b1, b == 0, 1'b0, b == 0, 16'(b), 16'(b));
    end
    cfg_commit = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (err !== 1'b0 || swap_pending !== 1'b0 || out_valid !== 1'b0 || out_q_y !== 20'd0) begin
      n_err++;
      $display("FAIL reset_mid: got err=%b pending=%b valid=%b q_y=%h, want 0",
               err, swap_pending, out_valid, out_q_y);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 32; b++) begin
      drive(1'b1, b == 0, b == 31, b == 0, 16'(b + 40), 16'(b + 80));
      n_cmp++;
      if (out_q_y !== ONES || out_q_cb !== ONES || out_data !== {16'(b + 80), 16'(b + 40)}) begin
        n_err++;
        $display("FAIL reset_mid_block beat%0d: got q_y=%h q_cb=%h data=%h, want 1 1",
                 b, out_q_y, out_q_cb, out_data);
      end
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_err: got %b, want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_commit_mid();
    test_commit_same_cycle();
    test_zero_guard();
    test_framing_err();
    test_en_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
